timer_tick_sequencer: RTL and testbench
=======================================

Name: timer_tick_sequencer

Overview:
- Avalon-MM master that configures and services the 16-bit-register interval timer slave (s1: address[2:0], chipselect, write_n, writedata[15:0], readdata[15:0], irq).
- Programs the period, starts the timer in one-shot or continuous mode, and clears the timeout status on each irq.
- Emits a one-cycle game tick per timeout and keeps a tick count.
- Reads back the counter snapshot on request. Sits between game-logic control and the timer instance.

Parameters:
- CTRL_ITO, 1, drive control[0] (interrupt enable) when starting.
- TICK_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: load cfg_period and cfg_continuous, program and start the timer
- cfg_period  in  32  timer period in clk cycles
- cfg_continuous  in  1  1 = continuous, 0 = one-shot
- stop_req  in  1  pulse: stop the timer
- snap_req  in  1  pulse: capture and read the counter snapshot
- tmr_address  out  3  timer s1 address
- tmr_chipselect  out  1  timer s1 chipselect
- tmr_write_n  out  1  timer s1 write strobe, active-low
- tmr_writedata  out  16  timer s1 write data
- tmr_readdata  in  16  timer s1 read data, registered in the slave
- tmr_irq  in  1  timer interrupt, level
- busy  out  1  sequencer not in IDLE or RUN
- running  out  1  timer believed running
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts, wraps
- snap_valid  out  1  one-cycle pulse, snapshot updated
- snapshot  out  32  last snapshot value
- cfg_error  out  1  one-cycle pulse, cfg_start with period 0 rejected

Behaviour:
- Reset (async, active-high):
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
  - busy=0, running=0, tick=0, tick_count=0, snap_valid=0, snapshot=0, cfg_error=0. State IDLE.
- Slave has no waitrequest: every write completes in its single cycle.
- Writes: chipselect=1, write_n=0 for exactly one cycle. Outside write cycles chipselect=0, write_n=1.
- Reads: readdata is valid the cycle after the address is presented.
- Period and continuous mode are latched on an accepted cfg_start.
- States and transitions:
  - IDLE:
    - cfg_start with period!=0 -> WR_PL.
    - cfg_start with period==0 -> cfg_error pulse, stay in IDLE, no bus activity.
    - snap_req -> SNAP_WR.
    - stop_req -> STOP_WR.
  - WR_PL: write address 2, data period[15:0] -> WR_PH.
  - WR_PH: write address 3, data period[31:16] -> WR_CTRL.
    - The period write force-reloads and stops the timer, so the control write must follow it.
  - WR_CTRL: write address 1, data {STOP=0, START=1, CONT=cfg_continuous, ITO=CTRL_ITO} -> RUN, running=1.
  - RUN: priority stop_req > tmr_irq > cfg_start > snap_req.
    - stop_req -> STOP_WR.
    - tmr_irq -> CLR_TO.
    - cfg_start -> WR_PL (reprogram); period 0 gives cfg_error and stays in RUN.
    - snap_req -> SNAP_WR.
  - CLR_TO: write address 0, data 0; tick=1; tick_count+1.
    - Continuous -> RUN.
    - One-shot -> IDLE with running=0.
  - STOP_WR: write address 1, data 4'b1000 (STOP) -> IDLE, running=0.
  - SNAP_WR: write address 4, data 0 (latches snapshot) -> SNAP_RL.
  - SNAP_RL: read address 4 -> SNAP_RH.
  - SNAP_RH: present address 5; capture readdata into snapshot[15:0] -> SNAP_CAP.
  - SNAP_CAP: capture readdata into snapshot[31:16]; snap_valid=1 -> RUN if running, else IDLE.
- Requests during busy states:
  - cfg_start and snap_req are dropped.
  - stop_req is latched pending and serviced on the next entry to RUN/IDLE, ahead of all else.
  - tmr_irq is level, so it is not lost while busy; serviced on return to RUN.
- The irq is cleared within 1 cycle of the RUN-state decision. The irq stays asserted until the write lands; the sequencer must not issue a second CLR_TO for the same timeout (the irq drop is observed the cycle after the write).
- tick_count wraps from 2^TICK_W-1 to 0.
- Reset mid-sequence aborts immediately. Bus outputs go idle; no partial-write cleanup.

Test Plan:
- cfg_start, period=50000 (0x0000C350), continuous=1 -> writes (addr2, 0xC350), (addr3, 0x0000), (addr1, 0x7) on consecutive cycles; running=1, busy=0 after.
- Timer model irq every 50000 cycles, 3 timeouts -> 3 writes (addr0, 0), 3 tick pulses, tick_count=3, running stays 1.
- One-shot, period=10 -> single tick, state IDLE, running=0; no further bus activity.
- In RUN, snap_req with model counter=0x0001_2345 -> write addr4; reads addr4, addr5; snapshot=0x00012345, snap_valid pulses once, returns to RUN.
- stop_req asserted same cycle as tmr_irq -> STOP write (addr1, 0x8) first, then IDLE; no tick. cfg_start with period 0 -> cfg_error pulse, no writes.
- Reset asserted during WR_PH -> chipselect=0 and write_n=1 immediately, all outputs at reset values; tick_count wrap checked with TICK_W=2 after 4 ticks -> 0.

Source files
------------

// File: rtl/timer_tick_sequencer_if.sv
// timer_tick_sequencer_if: Avalon-MM link to the 16-bit interval timer slave (s1)
//   tmr_address    master->slave  register select
//   tmr_chipselect master->slave  asserted only during write cycles
//   tmr_write_n    master->slave  active-low write strobe
//   tmr_writedata  master->slave  register write data
//   tmr_readdata   slave->master  registered read data, valid the cycle after the address
//   tmr_irq        slave->master  timeout interrupt, level
interface timer_tick_sequencer_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );
  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer: programs the interval timer, services its timeouts as game ticks, reads snapshots
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_start/period/continuous  program period and mode, then start the timer
//   stop_req, snap_req         stop the timer / capture and read the counter snapshot
//   tmr                        Avalon-MM master port to the timer s1 slave
//   busy, running              sequencer in a bus sequence / timer believed running
//   tick, tick_count           one-cycle pulse and wrapping count per serviced timeout
//   snap_valid, snapshot       one-cycle pulse as snapshot updates / last snapshot
//   cfg_error                  one-cycle pulse when a zero period is rejected
module timer_tick_sequencer #(
  parameter logic CTRL_ITO = 1'b1,
  parameter int   TICK_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  stop_req,
  input  logic                  snap_req,
  timer_tick_sequencer_if.master tmr,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_W-1:0]     tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snapshot,
  output logic                  cfg_error
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_TO, STOP_WR, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_t;
  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                cont_q, cont_d;
  logic                running_q, running_d;
  logic                stop_pend_q, stop_pend_d;
  logic                tick_q, tick_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic                snap_valid_q, snap_valid_d;
  logic [31:0]         snapshot_q, snapshot_d;
  logic                cfg_error_q, cfg_error_d;
  logic                stop_any;
  logic                bus_wr;
  logic [2:0]          bus_addr;
  logic [15:0]         bus_wd;
  assign busy       = (state_q != IDLE) && (state_q != RUN);
  assign running    = running_q;
  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign snap_valid = snap_valid_q;
  assign snapshot   = snapshot_q;
  assign cfg_error  = cfg_error_q;
  // Bus strobes decode straight from the state register so an async reset idles the bus at once.
  assign tmr.tmr_address    = bus_addr;
  assign tmr.tmr_chipselect = bus_wr;
  assign tmr.tmr_write_n    = !bus_wr;
  assign tmr.tmr_writedata  = bus_wd;
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    running_d    = running_q;
    stop_pend_d  = stop_pend_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    snap_valid_d = 1'b0;
    snapshot_d   = snapshot_q;
    cfg_error_d  = 1'b0;
    bus_wr       = 1'b0;
    bus_addr     = 3'd0;
    bus_wd       = 16'd0;
    stop_any     = stop_req | stop_pend_q;
    // A stop arriving mid-sequence is held and honoured on the next return to IDLE/RUN.
    if (busy && stop_req) stop_pend_d = 1'b1;
    case (state_q)
      IDLE, RUN: begin
        if (stop_any) begin
          state_d     = STOP_WR;
          stop_pend_d = 1'b0;
        end else if (state_q == RUN && tmr.tmr_irq) begin
          state_d = CLR_TO;
        end else if (cfg_start && cfg_period == 32'd0) begin
          cfg_error_d = 1'b1;
        end else if (cfg_start) begin
          state_d  = WR_PL;
          period_d = cfg_period;
          cont_d   = cfg_continuous;
        end else if (snap_req) begin
          state_d = SNAP_WR;
        end
      end
      WR_PL: begin
        bus_wr   = 1'b1;
        bus_addr = 3'd2;
        bus_wd   = period_q[15:0];
        state_d  = WR_PH;
      end
      // The period write reloads and stops the timer, so the control write must come after it.
      WR_PH: begin
        bus_wr   = 1'b1;
        bus_addr = 3'd3;
        bus_wd   = period_q[31:16];
        state_d  = WR_CTRL;
      end
      WR_CTRL: begin
        bus_wr    = 1'b1;
        bus_addr  = 3'd1;
        bus_wd    = {12'd0, 1'b0, 1'b1, cont_q, CTRL_ITO};
        running_d = 1'b1;
        state_d   = RUN;
      end
      // The irq drops the cycle after this write, so RUN never sees the same timeout twice.
      CLR_TO: begin
        bus_wr       = 1'b1;
        tick_d       = 1'b1;
        tick_count_d = tick_count_q + TICK_W'(1);
        running_d    = cont_q ? running_q : 1'b0;
        state_d      = cont_q ? RUN : IDLE;
      end
      STOP_WR: begin
        bus_wr    = 1'b1;
        bus_addr  = 3'd1;
        bus_wd    = 16'h0008;
        running_d = 1'b0;
        state_d   = IDLE;
      end
      SNAP_WR: begin
        bus_wr   = 1'b1;
        bus_addr = 3'd4;
        state_d  = SNAP_RL;
      end
      SNAP_RL: begin
        bus_addr = 3'd4;
        state_d  = SNAP_RH;
      end
      SNAP_RH: begin
        bus_addr         = 3'd5;
        snapshot_d[15:0] = tmr.tmr_readdata;
        state_d          = SNAP_CAP;
      end
      SNAP_CAP: begin
        snapshot_d[31:16] = tmr.tmr_readdata;
        snap_valid_d      = 1'b1;
        state_d           = running_q ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Status pulses are registered so each one lines up with the count or snapshot it announces.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      running_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      snap_valid_q <= 1'b0;
      snapshot_q   <= '0;
      cfg_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      running_q    <= running_d;
      stop_pend_q  <= stop_pend_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      snap_valid_q <= snap_valid_d;
      snapshot_q   <= snapshot_d;
      cfg_error_q  <= cfg_error_d;
    end
  end
endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb_timer_tick_sequencer: directed bench with a behavioural interval-timer slave model
module tb_timer_tick_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_continuous = 1'b0;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        busy, running, tick, snap_valid, cfg_error;
  logic [15:0] tick_count;
  logic [31:0] snapshot;
  logic        cfg_start2 = 1'b0;
  logic        zero2 = 1'b0;
  logic        busy2, running2, tick2, snap_valid2, cfg_error2;
  logic [1:0]  tick_count2;
  logic [31:0] snapshot2;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  timer_tick_sequencer_if bus ();
  timer_tick_sequencer_if bus2 ();
  timer_tick_sequencer #(.CTRL_ITO(1'b1), .TICK_W(16)) u_dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req), .tmr(bus),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_valid(snap_valid), .snapshot(snapshot), .cfg_error(cfg_error)
  );
  timer_tick_sequencer #(.CTRL_ITO(1'b1), .TICK_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start2), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .stop_req(zero2), .snap_req(zero2), .tmr(bus2),
    .busy(busy2), .running(running2), .tick(tick2), .tick_count(tick_count2),
    .snap_valid(snap_valid2), .snapshot(snapshot2), .cfg_error(cfg_error2)
  );
  // Timer model: counts down from the period, timeout every `period` cycles, registered readdata.
  logic [31:0] m_per, m_cnt, m_snap;
  logic        m_run, m_cont, m_to, m_ito;
  logic [15:0] m_rd;
  logic        hold = 1'b0, set_to = 1'b0, clr_to = 1'b0, load = 1'b0;
  logic [31:0] load_val = 32'd0;
  assign bus.tmr_irq      = m_to & m_ito;
  assign bus.tmr_readdata = m_rd;
  always @(posedge clk) begin
    if (reset) begin
      m_per <= '0; m_cnt <= '0; m_snap <= '0; m_run <= 1'b0;
      m_cont <= 1'b0; m_to <= 1'b0; m_ito <= 1'b0; m_rd <= '0;
    end else begin
      m_rd <= (bus.tmr_address == 3'd4) ? m_snap[15:0] : (bus.tmr_address == 3'd5) ? m_snap[31:16] : 16'd0;
      if (m_run && !hold) begin
        if (m_cnt <= 32'd1) begin
          m_to  <= 1'b1;
          m_cnt <= m_per;
          if (!m_cont) m_run <= 1'b0;
        end else m_cnt <= m_cnt - 32'd1;
      end
      if (set_to) m_to <= 1'b1;
      if (clr_to) m_to <= 1'b0;
      if (load) m_cnt <= load_val;
      if (bus.tmr_chipselect && !bus.tmr_write_n) begin
        case (bus.tmr_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= bus.tmr_writedata[0];
            m_cont <= bus.tmr_writedata[1];
            if (bus.tmr_writedata[3]) m_run <= 1'b0;
            else if (bus.tmr_writedata[2]) m_run <= 1'b1;
          end
          3'd2: begin
            m_per[15:0] <= bus.tmr_writedata;
            m_cnt <= {m_per[31:16], bus.tmr_writedata};
            m_run <= 1'b0;
          end
          3'd3: begin
            m_per[31:16] <= bus.tmr_writedata;
            m_cnt <= {bus.tmr_writedata, m_per[15:0]};
            m_run <= 1'b0;
          end
          3'd4, 3'd5: m_snap <= m_cnt;
          default: ;
        endcase
      end
    end
  end
  // Second timer stand-in: bench raises irq, a clear write drops it.
  logic irq2 = 1'b0, set2 = 1'b0;
  assign bus2.tmr_irq      = irq2;
  assign bus2.tmr_readdata = 16'd0;
  always @(posedge clk) begin
    if (reset) irq2 <= 1'b0;
    else if (bus2.tmr_chipselect && !bus2.tmr_write_n && bus2.tmr_address == 3'd0) irq2 <= 1'b0;
    else if (set2) irq2 <= 1'b1;
  end
  // Bus monitor: every write as {addr,data} with its cycle stamp, plus pulse counters.
  logic [18:0] wa[$];
  int          wt[$];
  int          cyc_n = 0, n_tick = 0, n_snap = 0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.tmr_chipselect && !bus.tmr_write_n) begin
      wa.push_back({bus.tmr_address, bus.tmr_writedata});
      wt.push_back(cyc_n);
    end
    if (tick) n_tick <= n_tick + 1;
    if (snap_valid) n_snap <= n_snap + 1;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start_cfg(input logic [31:0] p, input logic c);
    cfg_period = p; cfg_continuous = c; cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1) begin
      errors++; $display("FAIL reset_bus: cs=%b wn=%b want cs=0 wn=1", bus.tmr_chipselect, bus.tmr_write_n);
    end
    checks++;
    if (bus.tmr_address !== 3'd0 || bus.tmr_writedata !== 16'd0) begin
      errors++; $display("FAIL reset_addr: addr=%0d wd=%h want 0 0", bus.tmr_address, bus.tmr_writedata);
    end
    checks++;
    if ({busy, running, tick, snap_valid, cfg_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy, running, tick, snap_valid, cfg_error});
    end
    checks++;
    if (tick_count !== 16'd0 || snapshot !== 32'd0) begin
      errors++; $display("FAIL reset_regs: tick_count=%0d snapshot=%h want 0 0", tick_count, snapshot);
    end
    reset = 1'b0;
    cyc();
  endtask
  task automatic test_program();
    int b = wa.size();
    start_cfg(32'h0000C350, 1'b1);
    repeat (4) cyc();
    checks++;
    if (wa.size() != b + 3) begin
      errors++; $display("FAIL prog_count: writes=%0d want 3", wa.size() - b);
    end
    checks++;
    if (wa[b] !== {3'd2, 16'hC350}) begin
      errors++; $display("FAIL prog_pl: got %h want %h", wa[b], {3'd2, 16'hC350});
    end
    checks++;
    if (wa[b+1] !== {3'd3, 16'h0000}) begin
      errors++; $display("FAIL prog_ph: got %h want %h", wa[b+1], {3'd3, 16'h0000});
    end
    checks++;
    if (wa[b+2] !== {3'd1, 16'h0007}) begin
      errors++; $display("FAIL prog_ctrl: got %h want %h", wa[b+2], {3'd1, 16'h0007});
    end
    checks++;
    if (wt[b+1] - wt[b] != 1 || wt[b+2] - wt[b+1] != 1) begin
      errors++; $display("FAIL prog_spacing: gaps %0d %0d want 1 1", wt[b+1] - wt[b], wt[b+2] - wt[b+1]);
    end
    checks++;
    if (running !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL prog_state: running=%b busy=%b want 1 0", running, busy);
    end
  endtask
  task automatic test_snapshot();
    int b = wa.size();
    int s0;
    int k = 0;
    hold = 1'b1; load_val = 32'h0001_2345; load = 1'b1;
    cyc();
    load = 1'b0;
    s0 = n_snap;
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
    while (snap_valid !== 1'b1 && k < 20) begin cyc(); k++; end
    checks++;
    if (k >= 20) begin errors++; $display("FAIL snap_timeout: snap_valid=%b want 1 within 20 cycles", snap_valid); end
    checks++;
    if (snapshot !== 32'h0001_2345) begin
      errors++; $display("FAIL snap_value: got %h want 00012345", snapshot);
    end
    repeat (3) cyc();
    checks++;
    if (n_snap - s0 != 1) begin errors++; $display("FAIL snap_pulses: got %0d want 1", n_snap - s0); end
    checks++;
    if (wa.size() != b + 1 || wa[b] !== {3'd4, 16'd0}) begin
      errors++; $display("FAIL snap_write: n=%0d first=%h want 1 %h", wa.size() - b, wa[b], {3'd4, 16'd0});
    end
    checks++;
    if (running !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL snap_return: running=%b busy=%b want 1 0", running, busy);
    end
  endtask
  task automatic test_stop_irq();
    int b = wa.size();
    int t0 = n_tick;
    set_to = 1'b1;
    cyc();
    set_to = 1'b0;
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    repeat (4) cyc();
    checks++;
    if (wa.size() != b + 1 || wa[b] !== {3'd1, 16'h0008}) begin
      errors++; $display("FAIL stop_write: n=%0d first=%h want 1 %h", wa.size() - b, wa[b], {3'd1, 16'h0008});
    end
    checks++;
    if (n_tick != t0 || tick_count !== 16'd0) begin
      errors++; $display("FAIL stop_notick: ticks=%0d tick_count=%0d want 0 0", n_tick - t0, tick_count);
    end
    checks++;
    if (running !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_state: running=%b busy=%b want 0 0", running, busy);
    end
    clr_to = 1'b1;
    cyc();
    clr_to = 1'b0; hold = 1'b0;
    b = wa.size();
    start_cfg(32'd0, 1'b1);
    checks++;
    if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfgerr_pulse: got %b want 1", cfg_error); end
    cyc();
    checks++;
    if (cfg_error !== 1'b0) begin errors++; $display("FAIL cfgerr_width: got %b want 0", cfg_error); end
    repeat (3) cyc();
    checks++;
    if (wa.size() != b || busy !== 1'b0) begin
      errors++; $display("FAIL cfgerr_nobus: writes=%0d busy=%b want 0 0", wa.size() - b, busy);
    end
  endtask
  task automatic test_pending_stop();
    int b = wa.size();
    start_cfg(32'd20, 1'b1);
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    repeat (6) cyc();
    checks++;
    if (wa.size() != b + 4) begin errors++; $display("FAIL pend_count: writes=%0d want 4", wa.size() - b); end
    checks++;
    if (wa[b+2] !== {3'd1, 16'h0007} || wa[b+3] !== {3'd1, 16'h0008}) begin
      errors++; $display("FAIL pend_order: got %h %h want %h %h", wa[b+2], wa[b+3], {3'd1, 16'h0007}, {3'd1, 16'h0008});
    end
    checks++;
    if (wt[b+3] - wt[b+2] != 2) begin errors++; $display("FAIL pend_latency: gap=%0d want 2", wt[b+3] - wt[b+2]); end
    checks++;
    if (running !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL pend_state: running=%b busy=%b want 0 0", running, busy);
    end
  endtask
  task automatic test_continuous();
    int b = wa.size();
    int t0 = n_tick;
    int k = 0;
    int n0 = 0;
    int st[$];
    start_cfg(32'd100, 1'b1);
    while (n_tick != t0 + 3 && k < 1000) begin cyc(); k++; end
    checks++;
    if (k >= 1000) begin errors++; $display("FAIL cont_timeout: ticks=%0d want 3", n_tick - t0); end
    checks++;
    if (tick_count !== 16'd3) begin errors++; $display("FAIL cont_count: got %0d want 3", tick_count); end
    for (int i = b; i < wa.size(); i++) if (wa[i][18:16] == 3'd0) begin n0++; st.push_back(wt[i]); end
    checks++;
    if (n0 != 3) begin errors++; $display("FAIL cont_clears: got %0d want 3", n0); end
    checks++;
    if (st.size() == 3 && (st[1] - st[0] != 100 || st[2] - st[1] != 100)) begin
      errors++; $display("FAIL cont_period: gaps %0d %0d want 100 100", st[1] - st[0], st[2] - st[1]);
    end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL cont_running: got %b want 1", running); end
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    repeat (4) cyc();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL cont_stop: running=%b want 0", running); end
  endtask
  task automatic test_oneshot();
    int b = wa.size();
    int t0 = n_tick;
    int tc = tick_count;
    int k = 0;
    int w;
    start_cfg(32'd10, 1'b0);
    while (n_tick != t0 + 1 && k < 200) begin cyc(); k++; end
    w = wa.size();
    repeat (50) cyc();
    checks++;
    if (k >= 200 || n_tick != t0 + 1) begin errors++; $display("FAIL one_ticks: got %0d want 1", n_tick - t0); end
    checks++;
    if (wa[b+2] !== {3'd1, 16'h0005} || wa[w-1] !== {3'd0, 16'h0000}) begin
      errors++; $display("FAIL one_writes: ctrl=%h last=%h want %h %h", wa[b+2], wa[w-1], {3'd1, 16'h0005}, {3'd0, 16'h0000});
    end
    checks++;
    if (wa.size() != w) begin errors++; $display("FAIL one_quiet: extra writes=%0d want 0", wa.size() - w); end
    checks++;
    if (int'(tick_count) != tc + 1) begin errors++; $display("FAIL one_count: got %0d want %0d", tick_count, tc + 1); end
    checks++;
    if (running !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL one_state: running=%b busy=%b want 0 0", running, busy);
    end
  endtask
  task automatic test_reset_mid();
    int b = wa.size();
    start_cfg(32'h1234_5678, 1'b1);
    cyc();
    checks++;
    if (bus.tmr_address !== 3'd3 || bus.tmr_chipselect !== 1'b1 || bus.tmr_writedata !== 16'h1234) begin
      errors++; $display("FAIL rmid_phase: addr=%0d cs=%b wd=%h want 3 1 1234", bus.tmr_address, bus.tmr_chipselect, bus.tmr_writedata);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1 || bus.tmr_address !== 3'd0 || bus.tmr_writedata !== 16'd0) begin
      errors++; $display("FAIL rmid_bus: cs=%b wn=%b addr=%0d wd=%h want 0 1 0 0", bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata);
    end
    checks++;
    if (busy !== 1'b0 || running !== 1'b0 || tick_count !== 16'd0 || snapshot !== 32'd0) begin
      errors++; $display("FAIL rmid_regs: busy=%b running=%b tc=%0d snap=%h want 0 0 0 0", busy, running, tick_count, snapshot);
    end
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (wa.size() != b + 1) begin errors++; $display("FAIL rmid_writes: got %0d want 1", wa.size() - b); end
  endtask
  task automatic test_wrap();
    start_cfg(32'd5, 1'b1);
    cfg_start2 = 1'b1;
    cyc();
    cfg_start2 = 1'b0;
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      set2 = 1'b1;
      cyc();
      set2 = 1'b0;
      while (tick2 !== 1'b1 && k < 20) begin cyc(); k++; end
      checks++;
      if (k >= 20) begin errors++; $display("FAIL wrap_tick%0d: tick2=%b want 1 within 20 cycles", i, tick2); end
      if (i == 2) begin
        checks++;
        if (tick_count2 !== 2'd3) begin errors++; $display("FAIL wrap_three: got %0d want 3", tick_count2); end
      end
      if (i == 3) begin
        checks++;
        if (tick_count2 !== 2'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", tick_count2); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_program();
    test_snapshot();
    test_stop_irq();
    test_pending_stop();
    test_continuous();
    test_oneshot();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
